// File: rtl/if_stage_pkg.sv
// Shared RV32I fetch definitions: widths, NOP encoding, fetch FSM states and
// the {instr, pc} entry carried by the IF/ID register and skid buffer.
package if_stage_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INST_WIDTH = 32;

  // addi x0, x0, 0
  localparam logic [INST_WIDTH-1:0] NOP_ENC = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DROP  = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [INST_WIDTH-1:0] instr;
    logic [XLEN-1:0]       pc;
  } fetch_entry_t;

  // Clear the byte-offset bits of an address.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {instr, pc} holding register that absorbs a fetch response
// arriving while the IF/ID register is stalled.
module if_skid_buf
  import if_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  drain,
  input  logic                  clear,
  input  logic [INST_WIDTH-1:0] load_instr,
  input  logic [XLEN-1:0]       load_pc,
  output logic                  valid,
  output logic [INST_WIDTH-1:0] instr,
  output logic [XLEN-1:0]       pc
);

  fetch_entry_t entry_q;
  logic         valid_q;

  // clear (redirect) beats load, load beats drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q       <= 1'b1;
      entry_q.instr <= load_instr;
      entry_q.pc    <= load_pc;
    end else if (drain) begin
      valid_q <= 1'b0;
    end
  end

  assign valid = valid_q;
  assign instr = entry_q.instr;
  assign pc    = entry_q.pc;

endmodule

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: PC, next-PC selection, single-outstanding
// IMEM port and the IF/ID register. Optional IF_PERF_COUNTERS_EN adds counters.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0]       RESET_PC  = 32'h0000_0000,
  parameter logic [INST_WIDTH-1:0] NOP_INSTR = NOP_ENC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [XLEN-1:0]       redirect_pc_i,
  output logic                  imem_req_o,
  output logic [XLEN-1:0]       imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [INST_WIDTH-1:0] imem_rdata_i,
  output logic                  if_id_valid_o,
  output logic [INST_WIDTH-1:0] if_id_instr_o,
  output logic [XLEN-1:0]       if_id_pc_o
`ifdef IF_PERF_COUNTERS_EN
  ,
  output logic [31:0]           perf_fetched_o,
  output logic [31:0]           perf_stall_o
`endif
);

  fetch_state_e          state_q;
  fetch_state_e          state_nxt;
  logic [XLEN-1:0]       pc_q;

  logic                  xfer;
  logic                  accept;
  logic                  skid_load;
  logic                  skid_drain;

  logic                  skid_valid;
  logic [INST_WIDTH-1:0] skid_instr;
  logic [XLEN-1:0]       skid_pc;

  logic                  if_id_valid_q;
  logic [INST_WIDTH-1:0] if_id_instr_q;
  logic [XLEN-1:0]       if_id_pc_q;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // FSM next state; a response that lands with a redirect ends the outstanding
  // fetch, so nothing is left to drop
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      ST_IDLE: begin
        state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (redirect_i) begin
          state_nxt = xfer ? ST_DROP : ST_FETCH;
        end else if (xfer) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid_i) begin
          state_nxt = ST_FETCH;
        end else if (redirect_i) begin
          state_nxt = ST_DROP;
        end
      end
      ST_DROP: begin
        if (imem_rvalid_i) begin
          state_nxt = ST_FETCH;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM outputs and datapath strobes
  always_comb begin
    imem_req_o = 1'b0;
    xfer       = 1'b0;
    accept     = 1'b0;
    skid_load  = 1'b0;
    skid_drain = 1'b0;

    imem_req_o = (state_q == ST_FETCH) && !skid_valid && !redirect_i;
    xfer       = imem_req_o && imem_gnt_i;
    accept     = (state_q == ST_WAIT) && imem_rvalid_i && !redirect_i;
    skid_load  = accept && stall_i;
    skid_drain = skid_valid && !stall_i && !redirect_i;
  end

  assign imem_addr_o = word_align(pc_q);

  // PC: redirect target, else advance when the current fetch returns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (redirect_i) begin
      pc_q <= word_align(redirect_pc_i);
    end else if ((state_q == ST_WAIT) && imem_rvalid_i) begin
      pc_q <= pc_q + XLEN'(4);
    end
  end

  if_skid_buf u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (skid_load),
    .drain      (skid_drain),
    .clear      (redirect_i),
    .load_instr (imem_rdata_i),
    .load_pc    (pc_q),
    .valid      (skid_valid),
    .instr      (skid_instr),
    .pc         (skid_pc)
  );

  // IF/ID register: redirect > skid drain > new response > bubble; stall holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_valid_q <= 1'b0;
      if_id_instr_q <= NOP_INSTR;
      if_id_pc_q    <= '0;
    end else if (redirect_i) begin
      if_id_valid_q <= 1'b0;
      if_id_instr_q <= NOP_INSTR;
    end else if (skid_drain) begin
      if_id_valid_q <= 1'b1;
      if_id_instr_q <= skid_instr;
      if_id_pc_q    <= skid_pc;
    end else if (accept && !stall_i) begin
      if_id_valid_q <= 1'b1;
      if_id_instr_q <= imem_rdata_i;
      if_id_pc_q    <= pc_q;
    end else if (!stall_i) begin
      if_id_valid_q <= 1'b0;
      if_id_instr_q <= NOP_INSTR;
    end
  end

  assign if_id_valid_o = if_id_valid_q;
  assign if_id_instr_o = if_id_instr_q;
  assign if_id_pc_o    = if_id_pc_q;

`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stall_q;

  // wrapping event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (accept) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if (stall_i && if_id_valid_q) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_fetched_o = perf_fetched_q;
  assign perf_stall_o   = perf_stall_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: table of per-cycle vectors for straight-line,
// stall and redirect behaviour, plus sequences for DROP, redirect+stall and reset.
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b1;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        if_id_valid_o;
  logic [31:0] if_id_instr_o;
  logic [31:0] if_id_pc_o;
`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] perf_fetched_o;
  logic [31:0] perf_stall_o;
`endif

  if_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_id_valid_o (if_id_valid_o),
    .if_id_instr_o (if_id_instr_o),
    .if_id_pc_o    (if_id_pc_o)
`ifdef IF_PERF_COUNTERS_EN
    ,
    .perf_fetched_o(perf_fetched_o),
    .perf_stall_o  (perf_stall_o)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;

  // IMEM model state: response lat cycles after grant
  int          lat = 1;
  int          cnt = 0;
  logic [31:0] paddr = '0;
  logic        xfer_q;
  logic [31:0] xaddr;
  logic        pre_req;
  logic [31:0] pre_addr;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] epc;
  } vec_t;

  vec_t v[18];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[11:0], 20'h00093};
  endfunction

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rpc,
                              input logic ereq, input logic [31:0] eaddr,
                              input logic evalid, input logic [31:0] epc);
    vec_t t;
    t.stall = s; t.redir = r; t.rpc = rpc;
    t.ereq = ereq; t.eaddr = eaddr; t.evalid = evalid; t.epc = epc;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle, entered just after a negedge: drive inputs, record the
  // pre-edge request, cross the posedge, then update the IMEM model.
  task automatic tick(input logic s, input logic r, input logic [31:0] rpc);
    stall_i = s;
    redirect_i = r;
    redirect_pc_i = rpc;
    #1;
    pre_req  = imem_req_o;
    pre_addr = imem_addr_o;
    xfer_q   = imem_req_o && imem_gnt_i;
    xaddr    = imem_addr_o;
    @(posedge clk);
    @(negedge clk);
    if (xfer_q) begin
      cnt   = lat;
      paddr = xaddr;
    end else if (cnt > 0) begin
      cnt--;
    end
    imem_rvalid_i = (cnt == 1);
    imem_rdata_i  = mem_word(paddr);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall_i = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = '0;
    imem_rvalid_i = 1'b0;
    cnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_ifid(input string name, input logic evalid, input logic [31:0] epc);
    chk({name, " valid"}, 32'(if_id_valid_o), 32'(evalid));
    chk({name, " instr"}, if_id_instr_o, evalid ? mem_word(epc) : NOP_ENC);
    if (evalid) chk({name, " pc"}, if_id_pc_o, epc);
  endtask

  initial begin
    // stall s, redirect r, target, pre-edge req/addr, post-edge valid/pc
    v[0]  = mk(0, 0, 0,        0, 32'h000, 0, 0);
    v[1]  = mk(0, 0, 0,        1, 32'h000, 0, 0);
    v[2]  = mk(0, 0, 0,        0, 32'h000, 1, 32'h000);
    v[3]  = mk(0, 0, 0,        1, 32'h004, 0, 0);
    v[4]  = mk(0, 0, 0,        0, 32'h004, 1, 32'h004);
    v[5]  = mk(1, 0, 0,        1, 32'h008, 1, 32'h004);
    v[6]  = mk(1, 0, 0,        0, 32'h008, 1, 32'h004);
    v[7]  = mk(1, 0, 0,        0, 32'h00C, 1, 32'h004);
    v[8]  = mk(1, 0, 0,        0, 32'h00C, 1, 32'h004);
    v[9]  = mk(1, 0, 0,        0, 32'h00C, 1, 32'h004);
    v[10] = mk(0, 0, 0,        0, 32'h00C, 1, 32'h008);
    v[11] = mk(0, 0, 0,        1, 32'h00C, 0, 0);
    v[12] = mk(0, 0, 0,        0, 32'h00C, 1, 32'h00C);
    v[13] = mk(0, 0, 0,        1, 32'h010, 0, 0);
    v[14] = mk(0, 1, 32'h103,  0, 32'h010, 0, 0);
    v[15] = mk(0, 0, 0,        1, 32'h100, 0, 0);
    v[16] = mk(0, 0, 0,        0, 32'h100, 1, 32'h100);
    v[17] = mk(0, 0, 0,        1, 32'h104, 0, 0);

    // reset values
    lat = 1;
    do_reset();
    #1;
    chk("rst valid", 32'(if_id_valid_o), 32'd0);
    chk("rst instr", if_id_instr_o, NOP_ENC);
    chk("rst pc", if_id_pc_o, 32'h0);
    chk("rst req", 32'(imem_req_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    do_reset();

    // straight-line, stall/skid and redirect-in-WAIT vectors
    for (int i = 0; i < 18; i++) begin
      tick(v[i].stall, v[i].redir, v[i].rpc);
      chk($sformatf("v%0d req", i + 1), 32'(pre_req), 32'(v[i].ereq));
      chk($sformatf("v%0d addr", i + 1), pre_addr, v[i].eaddr);
      chk_ifid($sformatf("v%0d", i + 1), v[i].evalid, v[i].epc);
    end

    // redirect + stall with the skid full: redirect wins, skid discarded
    do_reset();
    repeat (5) tick(0, 0, 0);
    tick(1, 0, 0);
    tick(1, 0, 0);
    tick(1, 1, 32'h200);
    chk_ifid("rs flush", 0, 0);
    tick(1, 0, 0);
    chk("rs req", 32'(pre_req), 32'd1);
    chk("rs addr", pre_addr, 32'h200);
    chk_ifid("rs stalled", 0, 0);
    tick(0, 0, 0);
    chk_ifid("rs target", 1, 32'h200);

    // DROP: redirect in WAIT, second redirect in DROP, one response dropped
    lat = 3;
    do_reset();
    tick(0, 0, 0);
    tick(0, 0, 0);
    tick(0, 1, 32'h040);
    chk_ifid("dr redirect", 0, 0);
    tick(0, 1, 32'h080);
    tick(0, 0, 0);
    chk("dr hold req", 32'(pre_req), 32'd0);
    chk_ifid("dr dropped", 0, 0);
    tick(0, 0, 0);
    chk("dr req", 32'(pre_req), 32'd1);
    chk("dr addr", pre_addr, 32'h080);
    tick(0, 0, 0);
    tick(0, 0, 0);
    tick(0, 0, 0);
    chk_ifid("dr target", 1, 32'h080);

    // async reset while in WAIT with a response on the bus
    lat = 1;
    do_reset();
    repeat (4) tick(0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr valid", 32'(if_id_valid_o), 32'd0);
    chk("mr instr", if_id_instr_o, NOP_ENC);
    chk("mr pc", if_id_pc_o, 32'h0);
    chk("mr req", 32'(imem_req_o), 32'd0);
    do_reset();
    tick(0, 0, 0);
    chk("mr idle req", 32'(pre_req), 32'd0);
    tick(0, 0, 0);
    chk("mr first req", 32'(pre_req), 32'd1);
    chk("mr first addr", pre_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the RV32I pipeline, directly upstream of the decode control unit.
- Owns the PC register and the next-PC selection: sequential +4, or a branch/jump redirect from EX.
- Drives a single-outstanding request/response instruction-memory port.
- Holds the IF/ID pipeline register (instruction, PC, valid) that the decoder reads, with stall and flush support.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, instruction presented on if_id_instr_o when the entry is invalid (addi x0,x0,0).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall_i  input  1  hold IF/ID contents (from hazard unit).
- redirect_i  input  1  taken branch / JAL / JALR resolved in EX.
- redirect_pc_i  input  32  redirect target.
- imem_req_o  output  1  fetch request valid.
- imem_addr_o  output  32  fetch address, word aligned.
- imem_gnt_i  input  1  request accepted this cycle.
- imem_rvalid_i  input  1  response valid.
- imem_rdata_i  input  32  fetched instruction.
- if_id_valid_o  output  1  IF/ID entry holds a real instruction.
- if_id_instr_o  output  32  instruction to decoder.
- if_id_pc_o  output  32  PC of if_id_instr_o.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, pc=RESET_PC, skid empty.
  - if_id_valid_o=0, if_id_instr_o=NOP_INSTR, if_id_pc_o=0, imem_req_o=0.
- IMEM protocol:
  - Request is transferred when imem_req_o && imem_gnt_i.
  - Response comes imem_rvalid_i at least 1 cycle after grant.
  - At most one request is outstanding.
  - imem_addr_o = pc, with bits [1:0] forced to 0.
- Request gating: imem_req_o = (state==FETCH) && !skid_valid && !redirect_i.
- States:
  - IDLE: next cycle go to FETCH (first request one cycle after reset release).
  - FETCH: on grant go to WAIT.
  - WAIT: on imem_rvalid_i, pc<=pc+4 (wraps modulo 2^32) and go to FETCH.
  - DROP: on imem_rvalid_i, discard rdata and go to FETCH; pc is unchanged, already holding the redirect target.
- Accepting a response (WAIT with rvalid, no redirect):
  - If !stall_i and skid empty: IF/ID <= {1, rdata, pc}.
  - If stall_i: the response goes into a 1-entry skid {rdata, pc}, skid_valid=1, and IF/ID holds.
- Skid drain: when skid_valid && !stall_i, IF/ID <= skid and skid clears. A fetch is never in flight while the skid is full.
- stall_i with no new data: IF/ID holds; the PC and FSM keep fetching until the skid fills.
- Flush when no new instruction is accepted: when !stall_i, IF/ID valid <= 0 and instr <= NOP_INSTR.
- Redirect (highest priority, overrides stall_i):
  - pc <= {redirect_pc_i[31:2],2'b00}.
  - IF/ID valid <= 0 with NOP; skid cleared.
  - State: WAIT (or FETCH granted this cycle) -> DROP; FETCH ungranted -> FETCH with the new pc; DROP stays DROP.
  - A response arriving in the same cycle as a redirect is discarded.
- Redirect while in DROP: the new target overwrites pc; exactly one response is still dropped.
- Throughput: one instruction every 2 cycles with a zero-wait-state IMEM (grant same cycle, rvalid next).
- Reset mid-operation: everything returns to reset values immediately. Any IMEM response arriving after reset release while in IDLE/FETCH is ignored, since the IMEM is reset together with this block.

Optional Feature:
- Macro: IF_PERF_COUNTERS_EN.
- With the macro:
  - Adds outputs perf_fetched_o[31:0] and perf_stall_o[31:0], both reset to 0, wrapping.
  - perf_fetched_o increments on every response accepted into IF/ID or the skid.
  - perf_stall_o increments on every cycle with stall_i && if_id_valid_o.
- Without the macro: the ports and counters do not exist.

Decomposition:
- Shared package (rv32i defs):
  - fetch FSM enum (IDLE, FETCH, WAIT, DROP);
  - NOP encoding constant;
  - INST_WIDTH / XLEN constants.
- Sub-module if_skid_buf: the 1-entry {instr, pc} holding register with valid, load, drain and clear.

Test Plan:
- Reset, then zero-wait IMEM returning 32'h00500093 at address 0: imem_req_o=1, addr 0 in the first cycle after release; if_id_valid_o=1, instr 32'h00500093, pc 0 two cycles later; next request addr 4.
- Straight-line fetch of 4 words: PCs 0,4,8,12 appear on if_id_pc_o, one every 2 cycles, never skipped or duplicated.
- stall_i held 5 cycles while a response for pc 8 arrives:
  - IF/ID holds pc 4; skid captures pc 8; imem_req_o=0.
  - After release, IF/ID shows pc 8 in the next cycle, then fetching resumes at 12.
- Redirect to 32'h0000_0103 during WAIT at pc 16:
  - IF/ID goes to NOP/invalid; the pc 16 response is discarded.
  - Next request addr 32'h0000_0100.
- redirect_i and stall_i together with the skid full: skid and IF/ID are cleared and the fetch goes to the target (redirect wins).
- rst_n pulsed low while in WAIT: outputs go to reset values immediately; after release the first request is at RESET_PC.
